flpv3l_mbus_power_seq: RTL and testbench

- Sequences the layer power-domain control signals LRC_SLEEP, LRC_CLKENB, LRC_RESET and LRC_ISOLATE. It drives the *_uniso inputs of flpv3l_mbus_isolation.
- Runs in the always-on MBus clock domain.
- On a wake request it releases sleep, clock, reset and isolation in that order, each with a programmable dwell.
- On a sleep request it re-asserts them in the reverse order, once the layer has no pending TX.

---
 rtl/flpv3l_mbus_power_seq.sv | 162 ++++++++++++++++
 tb/tb_flpv3l_mbus_power_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/flpv3l_mbus_power_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flpv3l_mbus_power_seq : layer power-domain wake/sleep sequencer           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module flpv3l_mbus_power_seq #(
  parameter int DLY_WIDTH = 4,
  parameter int T_SLEEP   = 4,
  parameter int T_CLK     = 2,
  parameter int T_RST     = 3,
  parameter int T_ISO     = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic MBC_ISOLATE,
  input  logic WAKEUP_REQ,
  input  logic SLEEP_REQ,
  input  logic TX_IDLE,
  output logic LRC_SLEEP_uniso,
  output logic LRC_CLKENB_uniso,
  output logic LRC_RESET_uniso,
  output logic LRC_ISOLATE_uniso,
  output logic SEQ_BUSY,
  output logic WAKE_DONE,
  output logic SLEEP_DONE
);

  localparam logic [2:0] c_ST_SLEEP  = 3'd0;
  localparam logic [2:0] c_ST_W_PWR  = 3'd1;
  localparam logic [2:0] c_ST_W_CLK  = 3'd2;
  localparam logic [2:0] c_ST_W_RST  = 3'd3;
  localparam logic [2:0] c_ST_ACTIVE = 3'd4;
  localparam logic [2:0] c_ST_S_ISO  = 3'd5;
  localparam logic [2:0] c_ST_S_RST  = 3'd6;
  localparam logic [2:0] c_ST_S_CLK  = 3'd7;

  // Dwell values of 0 behave as 1, so the terminal count saturates at 0.
  function automatic logic [DLY_WIDTH-1:0] f_lim(input int t);
    return (t <= 1) ? '0 : DLY_WIDTH'(t - 1);
  endfunction

  localparam logic [DLY_WIDTH-1:0] c_LIM_SLEEP = f_lim(T_SLEEP);
  localparam logic [DLY_WIDTH-1:0] c_LIM_CLK   = f_lim(T_CLK);
  localparam logic [DLY_WIDTH-1:0] c_LIM_RST   = f_lim(T_RST);
  localparam logic [DLY_WIDTH-1:0] c_LIM_ISO   = f_lim(T_ISO);
  localparam logic [DLY_WIDTH-1:0] c_CNT_ONE   = DLY_WIDTH'(1);

  logic [2:0]           r_state;
  logic [DLY_WIDTH-1:0] r_cnt;
  logic                 r_pend;
  logic                 r_wake_ent;
  logic                 r_sleep_ent;

  logic [2:0]           w_next;
  logic                 w_pend_next;
  logic [DLY_WIDTH-1:0] w_lim;
  logic                 w_cnt_done;
  logic                 w_trans;
  logic [3:0]           w_pat;

  always_comb begin
    w_lim = '0;
    case (r_state)
      c_ST_W_PWR:             w_lim = c_LIM_SLEEP;
      c_ST_W_CLK, c_ST_S_CLK: w_lim = c_LIM_CLK;
      c_ST_W_RST, c_ST_S_RST: w_lim = c_LIM_RST;
      c_ST_S_ISO:             w_lim = c_LIM_ISO;
      default:                w_lim = '0;
    endcase
  end

  assign w_cnt_done = (r_cnt == w_lim);
  assign w_trans    = (r_state != c_ST_SLEEP) && (r_state != c_ST_ACTIVE);

  always_comb begin
    w_next      = r_state;
    w_pend_next = r_pend;
    case (r_state)
      c_ST_SLEEP: begin
        if (WAKEUP_REQ || r_pend) begin
          w_next      = c_ST_W_PWR;
          w_pend_next = 1'b0;
        end
      end
      c_ST_W_PWR:  if (w_cnt_done) w_next = c_ST_W_CLK;
      c_ST_W_CLK:  if (w_cnt_done) w_next = c_ST_W_RST;
      c_ST_W_RST:  if (w_cnt_done) w_next = c_ST_ACTIVE;
      c_ST_ACTIVE: if (SLEEP_REQ && TX_IDLE && !WAKEUP_REQ) w_next = c_ST_S_ISO;
      c_ST_S_ISO, c_ST_S_RST, c_ST_S_CLK: begin
        // A wake seen while going down is remembered and replayed from SLEEP.
        if (WAKEUP_REQ) w_pend_next = 1'b1;
        if (w_cnt_done) begin
          case (r_state)
            c_ST_S_ISO: w_next = c_ST_S_RST;
            c_ST_S_RST: w_next = c_ST_S_CLK;
            default:    w_next = c_ST_SLEEP;
          endcase
        end
      end
      default: w_next = c_ST_SLEEP;
    endcase
    if (MBC_ISOLATE) begin
      w_next      = c_ST_SLEEP;
      w_pend_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= c_ST_SLEEP;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_wake_ent  <= 1'b0;
      r_sleep_ent <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pend      <= w_pend_next;
      r_wake_ent  <= (r_state == c_ST_W_RST) && (w_next == c_ST_ACTIVE);
      r_sleep_ent <= (r_state == c_ST_S_CLK) && (w_next == c_ST_SLEEP) && !MBC_ISOLATE;
      if (MBC_ISOLATE || (w_next != r_state)) begin
        r_cnt <= '0;
      end else if (w_trans) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  // Output pattern is {SLEEP, CLKENB, RESET, ISOLATE}.
  always_comb begin
    w_pat = 4'b1111;
    case (r_state)
      c_ST_SLEEP:             w_pat = 4'b1111;
      c_ST_W_PWR, c_ST_S_CLK: w_pat = 4'b0111;
      c_ST_W_CLK, c_ST_S_RST: w_pat = 4'b0011;
      c_ST_W_RST, c_ST_S_ISO: w_pat = 4'b0001;
      c_ST_ACTIVE:            w_pat = 4'b0000;
      default:                w_pat = 4'b1111;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LRC_SLEEP_uniso   <= 1'b1;
      LRC_CLKENB_uniso  <= 1'b1;
      LRC_RESET_uniso   <= 1'b1;
      LRC_ISOLATE_uniso <= 1'b1;
      SEQ_BUSY          <= 1'b0;
      WAKE_DONE         <= 1'b0;
      SLEEP_DONE        <= 1'b0;
    end else begin
      LRC_SLEEP_uniso   <= w_pat[3];
      LRC_CLKENB_uniso  <= w_pat[2];
      LRC_RESET_uniso   <= w_pat[1];
      LRC_ISOLATE_uniso <= w_pat[0];
      SEQ_BUSY          <= w_trans;
      WAKE_DONE         <= r_wake_ent;
      SLEEP_DONE        <= r_sleep_ent;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flpv3l_mbus_power_seq.sv
`default_nettype none
// Testbench for flpv3l_mbus_power_seq: directed plan steps followed by random
// traffic, all checked against a position/countdown reference model.
module tb_flpv3l_mbus_power_seq;

  localparam int P_SLEEP = 4;
  localparam int P_CLK   = 2;
  localparam int P_RST   = 3;
  localparam int P_ISO   = 2;

  logic CLK = 1'b0;
  logic RESET, MBC_ISOLATE, WAKEUP_REQ, SLEEP_REQ, TX_IDLE;
  logic o_sleep, o_clkenb, o_reset, o_iso, o_busy, o_wd, o_sd;
  logic [6:0] w_outs;

  flpv3l_mbus_power_seq #(
    .DLY_WIDTH(4), .T_SLEEP(P_SLEEP), .T_CLK(P_CLK), .T_RST(P_RST), .T_ISO(P_ISO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .MBC_ISOLATE(MBC_ISOLATE), .WAKEUP_REQ(WAKEUP_REQ),
    .SLEEP_REQ(SLEEP_REQ), .TX_IDLE(TX_IDLE),
    .LRC_SLEEP_uniso(o_sleep), .LRC_CLKENB_uniso(o_clkenb),
    .LRC_RESET_uniso(o_reset), .LRC_ISOLATE_uniso(o_iso),
    .SEQ_BUSY(o_busy), .WAKE_DONE(o_wd), .SLEEP_DONE(o_sd)
  );

  assign w_outs = {o_sleep, o_clkenb, o_reset, o_iso, o_busy, o_wd, o_sd};

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Reference: position on the 8-step power ring (0 = asleep, 4 = active),
  // remaining dwell cycles, and a remembered wake request.
  int pos, rem;
  bit pend, wevt, sevt;
  logic [6:0] exp_outs;
  logic [3:0] ring_pat [8] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001,
                               4'b0000, 4'b0001, 4'b0011, 4'b0111};

  function automatic int dwell(input int p);
    int t;
    case (p)
      1:       t = P_SLEEP;
      2, 7:    t = P_CLK;
      3, 6:    t = P_RST;
      5:       t = P_ISO;
      default: t = 0;
    endcase
    if (p != 0 && p != 4 && t < 1) t = 1;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    pos = 0; rem = 0; pend = 0; wevt = 0; sevt = 0;
  endtask

  task automatic model_edge();
    exp_outs = {ring_pat[pos], (pos != 0 && pos != 4), wevt, sevt};
    wevt = 0; sevt = 0;
    if (MBC_ISOLATE) begin
      pos = 0; rem = 0; pend = 0;
    end else if (pos == 0) begin
      if (WAKEUP_REQ || pend) begin pos = 1; rem = dwell(1); pend = 0; end
    end else if (pos == 4) begin
      if (SLEEP_REQ && TX_IDLE && !WAKEUP_REQ) begin pos = 5; rem = dwell(5); end
    end else begin
      if (pos >= 5 && WAKEUP_REQ) pend = 1;
      rem--;
      if (rem == 0) begin
        pos = (pos + 1) % 8;
        rem = dwell(pos);
        wevt = (pos == 4);
        sevt = (pos == 0);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("outs", 32'(w_outs), 32'(exp_outs));
  endtask

  task automatic mark(input int k, input bit cond, inout int t);
    if (cond && t < 0) t = k;
  endtask

  task automatic mid_reset();
    #3 RESET = 1'b1;
    #1 chk("async_rst_outs", 32'(w_outs), 32'h78);
    model_reset();
    #2 RESET = 1'b0;
  endtask

  initial begin
    int ta, tb, tc, td;
    RESET = 1'b1; MBC_ISOLATE = 0; WAKEUP_REQ = 0; SLEEP_REQ = 0; TX_IDLE = 1;
    model_reset();
    #12;
    chk("reset_outs", 32'(w_outs), 32'h78);
    @(negedge CLK) RESET = 1'b0;

    // Wake sequence from SLEEP.
    WAKEUP_REQ = 1; step(); WAKEUP_REQ = 0;
    ta = -1; tb = -1; tc = -1; td = -1;
    for (int k = 1; k <= 11; k++) begin
      step();
      mark(k, o_sleep == 0, ta); mark(k, o_clkenb == 0, tb);
      mark(k, o_reset == 0, tc); mark(k, o_iso == 0 && o_wd == 1, td);
    end
    chk("wake_sleep_rel", ta, 1); chk("wake_clk_rel", tb, 5);
    chk("wake_rst_rel", tc, 7);   chk("wake_done", td, 10);

    // Sleep sequence from ACTIVE.
    SLEEP_REQ = 1; TX_IDLE = 1; step(); SLEEP_REQ = 0;
    ta = -1; tb = -1; tc = -1; td = -1;
    for (int k = 1; k <= 9; k++) begin
      step();
      mark(k, o_iso == 1, ta); mark(k, o_reset == 1, tb);
      mark(k, o_clkenb == 1, tc); mark(k, o_sleep == 1 && o_sd == 1, td);
    end
    chk("sleep_iso", ta, 1); chk("sleep_rst", tb, 3);
    chk("sleep_clk", tc, 6); chk("sleep_done", td, 8);

    // Wake during the sleep sequence is replayed after SLEEP is reached.
    WAKEUP_REQ = 1; step(); WAKEUP_REQ = 0;
    for (int k = 1; k <= 10; k++) step();
    SLEEP_REQ = 1; step(); SLEEP_REQ = 0;
    ta = -1; tb = -1; tc = -1;
    for (int k = 1; k <= 19; k++) begin
      WAKEUP_REQ = (k == 4);
      step();
      mark(k, o_sleep == 1 && o_sd == 1, ta);
      mark(k, ta >= 0 && o_sleep == 0, tb);
      mark(k, o_iso == 0 && o_wd == 1, tc);
    end
    WAKEUP_REQ = 0;
    chk("pend_sleep_done", ta, 8); chk("pend_rewake", tb, 9); chk("pend_wake_done", tc, 18);

    // TX gating holds ACTIVE until TX_IDLE rises.
    SLEEP_REQ = 1; TX_IDLE = 0; ta = -1;
    for (int k = 0; k <= 22; k++) begin
      if (k == 20) TX_IDLE = 1;
      step();
      mark(k, o_iso == 1, ta);
    end
    chk("tx_gate_iso", ta, 21);
    SLEEP_REQ = 0;
    for (int k = 0; k < 8; k++) step();

    // MBC_ISOLATE override during W_CLK, requests ignored while it is held.
    WAKEUP_REQ = 1; step(); WAKEUP_REQ = 0;
    for (int k = 1; k <= 5; k++) step();
    MBC_ISOLATE = 1; WAKEUP_REQ = 1;
    step(); step();
    chk("mbc_force_sleep", 32'(w_outs), 32'h78);
    for (int k = 0; k < 12; k++) step();
    MBC_ISOLATE = 0;
    step(); WAKEUP_REQ = 0;
    for (int k = 0; k < 11; k++) step();

    // Asynchronous reset while in W_RST.
    SLEEP_REQ = 1; step(); SLEEP_REQ = 0;
    for (int k = 0; k < 9; k++) step();
    WAKEUP_REQ = 1; step(); WAKEUP_REQ = 0;
    for (int k = 1; k <= 7; k++) step();
    chk("pre_rst_in_wrst", 32'(w_outs), 32'h0c);
    mid_reset();
    WAKEUP_REQ = 1; step(); WAKEUP_REQ = 0;
    for (int k = 0; k < 12; k++) step();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      MBC_ISOLATE = ($urandom_range(0, 39) == 0);
      WAKEUP_REQ  = ($urandom_range(0, 5) == 0);
      SLEEP_REQ   = ($urandom_range(0, 2) == 0);
      TX_IDLE     = ($urandom_range(0, 2) != 0);
      step();
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
